// File: rtl/lot_pkg.sv
// Shared types and constants for the lottery draw sequencer: FSM states,
// number width and the 16-bit Fibonacci LFSR definition.
package lot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_GAP    = 3'd4,
        ST_FIM    = 3'd5,
        ST_JOGO   = 3'd6
    } lot_state_e;

    localparam int NUM_W  = 4;
    localparam int LFSR_W = 16;

    // x^16+x^14+x^13+x^11+1 for a right-shifting register: feedback from bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lot_draw_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; steps every cycle and reloads SEED on reset.
module lot_draw_lfsr
    import lot_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] state
);

    // An all-zero register is the lock-up state of an XOR LFSR.
    generate
        if (SEED == '0) begin : g_bad_seed
            $error("lot_draw_lfsr: SEED must be non-zero");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/lot_draw_sequencer.sv
// Draws rounds of pseudo-random nibbles and strobes them to the lottery checker.
// Optional feature macro LOT_DRAW_UNIQUE_EN: no number repeats within a round.
module lot_draw_sequencer
    import lot_pkg::*;
#(
    parameter int               N_DRAW = 4,
    parameter int               GAP    = 2,
    parameter int               ROUNDS = 3,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [0:NUM_W-1] num,
    output logic             insere,
    output logic             fim,
    output logic             fim_jogo,
    output logic             busy,
    output lot_state_e       state
);

    localparam logic [4:0] DRAW_LAST  = 5'(N_DRAW);
    localparam logic [3:0] GAP_LAST   = 4'(GAP);
    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS);

    generate
        if (N_DRAW < 1 || N_DRAW > 16) begin : g_bad_n_draw
            $error("lot_draw_sequencer: N_DRAW must be 1..16");
        end
        if (GAP < 0 || GAP > 15) begin : g_bad_gap
            $error("lot_draw_sequencer: GAP must be 0..15");
        end
        if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
            $error("lot_draw_sequencer: ROUNDS must be 1..15");
        end
    endgenerate

    logic [LFSR_W-1:0] lfsr_state;
    logic [NUM_W-1:0]  cand;
    logic              unused_lfsr_hi;
    logic              pick_ok;
    logic [4:0]        draw_cnt;
    logic [3:0]        gap_cnt;
    logic [3:0]        round_cnt;
    logic              last_draw;

    lot_draw_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .state (lfsr_state)
    );

    assign cand           = lfsr_state[NUM_W-1:0];
    assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:NUM_W];
    assign last_draw      = (draw_cnt + 5'd1) == DRAW_LAST;

`ifdef LOT_DRAW_UNIQUE_EN
    generate
        if (N_DRAW > 16) begin : g_unique_too_many
            $error("lot_draw_sequencer: unique draw needs N_DRAW <= 16");
        end
    endgenerate

    logic [(1<<NUM_W)-1:0] used_mask;

    // One bit per nibble value already drawn in the current round.
    always_ff @(posedge clk) begin
        if (reset) begin
            used_mask <= '0;
        end else if (state == ST_IDLE && start) begin
            used_mask <= '0;
        end else if (state == ST_PICK && !used_mask[cand]) begin
            used_mask[cand] <= 1'b1;
        end
    end

    assign pick_ok = !used_mask[cand];
`else
    assign pick_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            num       <= '0;
            insere    <= 1'b0;
            fim       <= 1'b0;
            fim_jogo  <= 1'b0;
            busy      <= 1'b0;
            draw_cnt  <= '0;
            gap_cnt   <= '0;
            round_cnt <= '0;
        end else begin
            insere   <= 1'b0;
            fim      <= 1'b0;
            fim_jogo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        draw_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (pick_ok) begin
                        num   <= cand;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    insere  <= 1'b1;
                    gap_cnt <= 4'd1;
                    // With no gap the strobe cycle itself closes the draw.
                    if (GAP_LAST == 4'd0) begin
                        draw_cnt <= draw_cnt + 5'd1;
                        state    <= last_draw ? ST_FIM : ST_PICK;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        draw_cnt <= draw_cnt + 5'd1;
                        state    <= last_draw ? ST_FIM : ST_PICK;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                ST_FIM: begin
                    fim       <= 1'b1;
                    round_cnt <= round_cnt + 4'd1;
                    if ((round_cnt + 4'd1) == ROUND_LAST) begin
                        state <= ST_JOGO;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_JOGO: begin
                    fim_jogo  <= 1'b1;
                    round_cnt <= '0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lot_draw_sequencer.sv
// Bench for lot_draw_sequencer: two instances (4 draws/gap 2/3 rounds and 16 draws/gap 0/1 round)
// checked against an independent LFSR model through per-instance event queues.
module tb_lot_draw_sequencer;
    import lot_pkg::*;

    localparam int A_N = 4;
    localparam int A_G = 2;
    localparam int A_R = 3;
    localparam int B_N = 16;
    localparam int B_G = 0;
    localparam int B_R = 1;
    localparam logic [15:0] TB_SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       start_a, start_b;
    logic [0:3] num_a, num_b;
    logic       insere_a, fim_a, fim_jogo_a, busy_a;
    logic       insere_b, fim_b, fim_jogo_b, busy_b;
    lot_state_e state_a, state_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] m;
    logic [15:0] pm;
    int          pe;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          rounds_a = 0;
    int          rounds_b = 0;
    int          strobes_b = 0;
    logic [15:0] seen_b = '0;

    lot_draw_sequencer #(.N_DRAW(A_N), .GAP(A_G), .ROUNDS(A_R), .SEED(TB_SEED)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .num(num_a), .insere(insere_a),
        .fim(fim_a), .fim_jogo(fim_jogo_a), .busy(busy_a), .state(state_a)
    );

    lot_draw_sequencer #(.N_DRAW(B_N), .GAP(B_G), .ROUNDS(B_R), .SEED(TB_SEED)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .num(num_b), .insere(insere_b),
        .fim(fim_b), .fim_jogo(fim_jogo_b), .busy(busy_b), .state(state_b)
    );

    // ---------------- clock / reference LFSR ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // m is the DUT LFSR value during the cycle following edge number cyc
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) m = TB_SEED;
        else       m = ref_step(m);
    end

    // event word: kind (1=insere 2=fim 3=fim_jogo), num, cycle
    function automatic logic [31:0] ev(input logic [1:0] k, input logic [3:0] v, input int c);
        return {k, v, c[25:0]};
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin : mon_a
        logic [1:0]  kind;
        logic [31:0] obs, x;
        if (!reset) begin
            kind = insere_a ? 2'd1 : fim_a ? 2'd2 : fim_jogo_a ? 2'd3 : 2'd0;
            if (kind != 2'd0) begin
                checks++;
                if ((int'(insere_a) + int'(fim_a) + int'(fim_jogo_a)) > 1) begin
                    errors++;
                    $display("FAIL a_exclusive: insere=%b fim=%b fim_jogo=%b at cycle %0d, required at most one high",
                             insere_a, fim_a, fim_jogo_a, cyc);
                end
                checks++;
                obs = ev(kind, num_a, cyc);
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_event: got kind=%0d num=%0d cycle=%0d, required no event",
                             obs[31:30], obs[29:26], obs[25:0]);
                end else begin
                    x = exp_a.pop_front();
                    if (obs !== x) begin
                        errors++;
                        $display("FAIL a_event: got kind=%0d num=%0d cycle=%0d, required kind=%0d num=%0d cycle=%0d",
                                 obs[31:30], obs[29:26], obs[25:0], x[31:30], x[29:26], x[25:0]);
                    end
                end
            end else if (exp_a.size() > 0 && int'(exp_a[0][25:0]) <= cyc) begin
                x = exp_a.pop_front();
                checks++;
                errors++;
                $display("FAIL a_missing: got no event at cycle %0d, required kind=%0d num=%0d",
                         x[25:0], x[31:30], x[29:26]);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [1:0]  kind;
        logic [31:0] obs, x;
        logic [3:0]  v;
        if (!reset) begin
            kind = insere_b ? 2'd1 : fim_b ? 2'd2 : fim_jogo_b ? 2'd3 : 2'd0;
            if (kind == 2'd1) begin
                v = num_b;
                seen_b[v] = 1'b1;
                strobes_b++;
            end
            if (kind != 2'd0) begin
                checks++;
                if ((int'(insere_b) + int'(fim_b) + int'(fim_jogo_b)) > 1) begin
                    errors++;
                    $display("FAIL b_exclusive: insere=%b fim=%b fim_jogo=%b at cycle %0d, required at most one high",
                             insere_b, fim_b, fim_jogo_b, cyc);
                end
                checks++;
                obs = ev(kind, num_b, cyc);
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_event: got kind=%0d num=%0d cycle=%0d, required no event",
                             obs[31:30], obs[29:26], obs[25:0]);
                end else begin
                    x = exp_b.pop_front();
                    if (obs !== x) begin
                        errors++;
                        $display("FAIL b_event: got kind=%0d num=%0d cycle=%0d, required kind=%0d num=%0d cycle=%0d",
                                 obs[31:30], obs[29:26], obs[25:0], x[31:30], x[29:26], x[25:0]);
                    end
                end
            end else if (exp_b.size() > 0 && int'(exp_b[0][25:0]) <= cyc) begin
                x = exp_b.pop_front();
                checks++;
                errors++;
                $display("FAIL b_missing: got no event at cycle %0d, required kind=%0d num=%0d",
                         x[25:0], x[31:30], x[29:26]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Predicts one round whose start is sampled at edge k; pm/pe carry the model LFSR.
    task automatic predict_round(input int sel, input int k, output int next_k);
        int          n, g, r, p, s, f, guard;
        bit          ok;
        logic [15:0] used;
        logic [3:0]  v;
        logic [31:0] q[$];
        n = (sel == 0) ? A_N : B_N;
        g = (sel == 0) ? A_G : B_G;
        r = (sel == 0) ? A_R : B_R;
        used = '0;
        v = '0;
        s = 0;
        p = k + 1;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            guard = 0;
            while (!ok) begin
                while (pe < p - 1) begin
                    pm = ref_step(pm);
                    pe++;
                end
                v = pm[3:0];
                ok = 1'b1;
`ifdef LOT_DRAW_UNIQUE_EN
                if (used[v] && guard < 70000) begin
                    ok = 1'b0;
                    p++;
                    guard++;
                end
`endif
            end
            used[v] = 1'b1;
            s = p + 2;
            q.push_back(ev(2'd1, v, s));
            p = s + g + 1;
        end
        f = s + g + 1;
        q.push_back(ev(2'd2, v, f));
        next_k = f + 1;
        if (sel == 0) begin
            rounds_a++;
            if (rounds_a == r) begin
                q.push_back(ev(2'd3, v, f + 1));
                rounds_a = 0;
                next_k = f + 2;
            end
        end else begin
            rounds_b++;
            if (rounds_b == r) begin
                q.push_back(ev(2'd3, v, f + 1));
                rounds_b = 0;
                next_k = f + 2;
            end
        end
        foreach (q[j]) begin
            if (sel == 0) exp_a.push_back(q[j]);
            else          exp_b.push_back(q[j]);
        end
    endtask

    task automatic start_round(input int sel);
        int   nk;
        logic got;
        pm = m;
        pe = cyc;
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        predict_round(sel, cyc + 1, nk);
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
        got = (sel == 0) ? busy_a : busy_b;
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start(%0d): got %b, required 1", sel, got);
        end
    endtask

    task automatic wait_idle(input int sel, input int budget);
        int   left;
        logic got;
        left = budget;
        while (((sel == 0) ? exp_a.size() : exp_b.size()) > 0 && left > 0) begin
            tick(1);
            left--;
        end
        checks++;
        if (left == 0) begin
            errors++;
            $display("FAIL wait_idle(%0d): timeout with %0d events pending, required 0", sel,
                     (sel == 0) ? exp_a.size() : exp_b.size());
            if (sel == 0) exp_a.delete();
            else          exp_b.delete();
        end
        got = (sel == 0) ? busy_a : busy_b;
        checks++;
        if (got !== 1'b0) begin
            errors++;
            $display("FAIL busy_when_idle(%0d): got %b, required 0", sel, got);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tick(3);
        checks++;
        if ({num_a, insere_a, fim_a, fim_jogo_a, busy_a} !== 8'h00 || state_a !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_a: got outputs=%h state=%0d, required 00 and 0",
                     {num_a, insere_a, fim_a, fim_jogo_a, busy_a}, state_a);
        end
        checks++;
        if ({num_b, insere_b, fim_b, fim_jogo_b, busy_b} !== 8'h00 || state_b !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_b: got outputs=%h state=%0d, required 00 and 0",
                     {num_b, insere_b, fim_b, fim_jogo_b, busy_b}, state_b);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            checks++;
            if ({num_a, insere_a, fim_a, fim_jogo_a, busy_a, num_b, insere_b, fim_b, fim_jogo_b, busy_b} !== 16'h0) begin
                errors++;
                $display("FAIL idle_quiet: got %h at cycle %0d, required 0000",
                         {num_a, insere_a, fim_a, fim_jogo_a, busy_a, num_b, insere_b, fim_b, fim_jogo_b, busy_b}, cyc);
            end
        end
    endtask

    task automatic test_single_round();
        start_round(0);
        wait_idle(0, 200);
    endtask

    task automatic test_game();
        for (int i = 0; i < 3; i++) begin
            start_round(0);
            wait_idle(0, 200);
        end
    endtask

    task automatic test_full_round_b();
        seen_b = '0;
        strobes_b = 0;
        start_round(1);
        wait_idle(1, 30000);
        checks++;
        if (strobes_b !== 16) begin
            errors++;
            $display("FAIL b_strobe_count: got %0d, required 16", strobes_b);
        end
`ifdef LOT_DRAW_UNIQUE_EN
        checks++;
        if (seen_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL b_permutation: got value set %h, required ffff", seen_b);
        end
`endif
    endtask

    task automatic test_start_held();
        int nk1, nk2, guard;
        pm = m;
        pe = cyc;
        start_a = 1'b1;
        predict_round(0, cyc + 1, nk1);
        predict_round(0, nk1, nk2);
        guard = 0;
        while (cyc < nk1 && guard < 1000) begin
            tick(1);
            guard++;
        end
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL held_second_round_busy: got %b, required 1", busy_a);
        end
        wait_idle(0, 400);
        tick(20);
        checks++;
        if (exp_a.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL held_no_extra: got pending=%0d busy=%b, required 0 and 0", exp_a.size(), busy_a);
        end
    endtask

    task automatic test_reset_mid_gap();
        int guard;
        start_round(0);
        wait_idle(0, 200);
        start_round(0);
        guard = 0;
        while (insere_a !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL mid_gap_strobe: got no insere in 50 cycles, required one");
        end
        tick(1);
        reset = 1'b1;
        exp_a.delete();
        rounds_a = 0;
        tick(1);
        checks++;
        if ({num_a, insere_a, fim_a, fim_jogo_a, busy_a} !== 8'h00 || state_a !== ST_IDLE) begin
            errors++;
            $display("FAIL mid_gap_reset: got outputs=%h state=%0d, required 00 and 0",
                     {num_a, insere_a, fim_a, fim_jogo_a, busy_a}, state_a);
        end
        reset = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            start_round(0);
            wait_idle(0, 200);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        test_reset();
        test_single_round();
        test_game();
        test_full_round_b();
        test_start_held();
        test_reset_mid_gap();
        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
